// File: rtl/irq_arbiter_if.sv
// Register-slave bus used by the correlator interrupt blocks.
// The master holds wr or rd high for one clock with a word address; a read
// returns its data one clock later with rvalid.
interface intbus_interf (
    input logic clk
);
    logic [31:0] addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport slave (
        input  addr, wr, rd, wdata,
        output rdata, rvalid
    );

    modport master (
        input  clk, rdata, rvalid,
        output addr, wr, rd, wdata
    );
endinterface

// File: rtl/irq_arbiter.sv
// Shares one CPU interrupt line between up to 32 edge-triggered sources.
// Rising edges are latched into PENDING. One masked pending source at a time
// is granted, by fixed priority or round-robin. irq stays active until
// software acknowledges the grant. A hold-off period then keeps irq idle
// before the next grant.
module irq_arbiter #(
    parameter int BASEADDR = 0,
    parameter int NSRC     = 8,
    parameter int HOLDOFF  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    intbus_interf.slave       bus,
    input  logic [NSRC-1:0]   src,
    output logic              irq
);

    localparam logic [15:0] IRQ_ARB_ID_CONST = 16'h1A4B;

    localparam logic [31:0] ADDR_ID      = 32'(BASEADDR);
    localparam logic [31:0] ADDR_CFG     = 32'(BASEADDR + 1);
    localparam logic [31:0] ADDR_MASK    = 32'(BASEADDR + 2);
    localparam logic [31:0] ADDR_PENDING = 32'(BASEADDR + 3);
    localparam logic [31:0] ADDR_CUR     = 32'(BASEADDR + 4);
    localparam logic [31:0] ADDR_ACK     = 32'(BASEADDR + 5);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cfg_q, cfg_d;
    logic [NSRC-1:0]   mask_q, mask_d;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   src_dly_q, src_dly_d;
    logic              cur_valid_q, cur_valid_d;
    logic [4:0]        cur_idx_q, cur_idx_d;
    logic [4:0]        last_q, last_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic              irq_q, irq_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic              enable;
    logic              polarity;
    logic              rr_mode;
    logic              wr_cfg;
    logic              wr_mask;
    logic              wr_pending;
    logic              wr_ack;
    logic [NSRC-1:0]   elig;
    logic [31:0]       elig32;
    logic [31:0]       cur_oh32;
    logic [NSRC-1:0]   ack_clr;
    logic [NSRC-1:0]   w1c_clr;
    logic              fp_found;
    logic [4:0]        fp_idx;
    logic              rr_found;
    logic [4:0]        rr_idx;
    logic              unused_bits;

    assign enable     = cfg_q[0];
    assign polarity   = cfg_q[1];
    assign rr_mode    = cfg_q[2];

    assign wr_cfg     = bus.wr && (bus.addr == ADDR_CFG);
    assign wr_mask    = bus.wr && (bus.addr == ADDR_MASK);
    assign wr_pending = bus.wr && (bus.addr == ADDR_PENDING);
    assign wr_ack     = bus.wr && (bus.addr == ADDR_ACK);

    assign elig       = pending_q & mask_q;
    assign elig32     = 32'(elig);
    assign cur_oh32   = 32'd1 << cur_idx_q;
    assign w1c_clr    = wr_pending ? bus.wdata[NSRC-1:0] : '0;
    assign unused_bits = ^bus.wdata;

    // Winner search: lowest eligible index, and first eligible index going upward circularly after last grant
    always_comb begin
        int j;
        j        = 0;
        fp_found = 1'b0;
        fp_idx   = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (!fp_found && elig32[k[4:0]]) begin
                fp_found = 1'b1;
                fp_idx   = k[4:0];
            end
        end
        for (int k = 0; k < NSRC; k++) begin
            j = int'(last_q) + 1 + k;
            if (j >= NSRC) begin
                j = j - NSRC;
            end
            if (!rr_found && elig32[j[4:0]]) begin
                rr_found = 1'b1;
                rr_idx   = j[4:0];
            end
        end
    end

    // Next-state logic for the grant FSM, edge capture, config registers, irq level and read data
    always_comb begin
        state_d     = state_q;
        cur_valid_d = cur_valid_q;
        cur_idx_d   = cur_idx_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        ack_clr     = '0;

        if (!enable) begin
            state_d     = IDLE;
            cur_valid_d = 1'b0;
            cur_idx_d   = '0;
            hold_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|elig) begin
                        state_d     = GRANT;
                        cur_valid_d = 1'b1;
                        cur_idx_d   = rr_mode ? rr_idx : fp_idx;
                    end
                end
                GRANT: begin
                    if (wr_ack) begin
                        ack_clr     = cur_oh32[NSRC-1:0];
                        last_d      = cur_idx_q;
                        cur_valid_d = 1'b0;
                        cur_idx_d   = '0;
                        hold_cnt_d  = 8'(HOLDOFF);
                        state_d     = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q <= 8'd1) begin
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        src_dly_d = src;
        pending_d = (pending_q & ~(w1c_clr | ack_clr)) | (src & ~src_dly_q);
        cfg_d     = wr_cfg  ? bus.wdata[2:0]      : cfg_q;
        mask_d    = wr_mask ? bus.wdata[NSRC-1:0] : mask_q;

        irq_d = ((state_q == GRANT) && enable) ? ~polarity : polarity;

        rvalid_d = bus.rd;
        rdata_d  = '0;
        if (bus.rd) begin
            if (bus.addr == ADDR_ID) begin
                rdata_d = {16'(NSRC), IRQ_ARB_ID_CONST};
            end else if (bus.addr == ADDR_CFG) begin
                rdata_d = {29'd0, cfg_q};
            end else if (bus.addr == ADDR_MASK) begin
                rdata_d = 32'(mask_q);
            end else if (bus.addr == ADDR_PENDING) begin
                rdata_d = 32'(pending_q);
            end else if (bus.addr == ADDR_CUR) begin
                rdata_d = {cur_valid_q, 26'd0, cur_idx_q};
            end
        end
    end

    // All state registers, cleared asynchronously so irq drops the moment reset asserts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            mask_q      <= '0;
            pending_q   <= '0;
            src_dly_q   <= '0;
            cur_valid_q <= 1'b0;
            cur_idx_q   <= '0;
            last_q      <= 5'(NSRC - 1);
            hold_cnt_q  <= '0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            mask_q      <= mask_d;
            pending_q   <= pending_d;
            src_dly_q   <= src_dly_d;
            cur_valid_q <= cur_valid_d;
            cur_idx_q   <= cur_idx_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign irq        = irq_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed bus/source sequences with literal expectations,
// plus a per-cycle comparison against a behavioural arbiter model.
module tb_irq_arbiter;

    localparam int BASE    = 16;
    localparam int NSRC    = 8;
    localparam int HOLDOFF = 4;

    logic       clk;
    logic       resetn;
    logic [7:0] src;
    logic       irq;

    int n_checks;
    int n_errors;

    intbus_interf bus (.clk(clk));

    irq_arbiter #(
        .BASEADDR (BASE),
        .NSRC     (NSRC),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .src    (src),
        .irq    (irq)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the values differ
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_pending;
    logic [7:0]  m_mask;
    logic [2:0]  m_cfg;
    int          m_grant;
    int          m_cool;
    int          m_last;
    logic        m_irq;
    logic [7:0]  m_src_prev;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    function automatic int pick(input logic [7:0] elig, input logic rr, input int last);
        if (!rr) begin
            for (int i = 0; i < NSRC; i++) begin
                if (((elig >> i) & 8'd1) != 8'd0) return i;
            end
        end else begin
            for (int k = 1; k <= NSRC; k++) begin
                int i2;
                i2 = (last + k) % NSRC;
                if (((elig >> i2) & 8'd1) != 8'd0) return i2;
            end
        end
        return -1;
    endfunction

    // Model advances on each rising edge using the inputs seen at that edge
    always @(posedge clk or negedge resetn) begin : model
        logic [7:0] rising;
        logic [7:0] clr;
        logic       en;
        logic       pol;
        logic       ack;
        int         off;
        if (!resetn) begin
            m_pending  = '0;
            m_mask     = '0;
            m_cfg      = '0;
            m_grant    = -1;
            m_cool     = 0;
            m_last     = NSRC - 1;
            m_irq      = 1'b0;
            m_src_prev = '0;
            m_rvalid   = 1'b0;
            m_rdata    = '0;
        end else begin
            rising     = src & ~m_src_prev;
            m_src_prev = src;
            en         = m_cfg[0];
            pol        = m_cfg[1];
            m_irq      = (m_grant >= 0 && en) ? ~pol : pol;
            off        = int'(bus.addr) - BASE;

            m_rvalid = bus.rd;
            m_rdata  = '0;
            if (bus.rd) begin
                case (off)
                    0: m_rdata = {16'(NSRC), 16'h1A4B};
                    1: m_rdata = {29'd0, m_cfg};
                    2: m_rdata = {24'd0, m_mask};
                    3: m_rdata = {24'd0, m_pending};
                    4: m_rdata = (m_grant >= 0) ? (32'h8000_0000 | 32'(m_grant)) : 32'd0;
                    default: m_rdata = '0;
                endcase
            end

            clr = '0;
            ack = bus.wr && (off == 5);
            if (!en) begin
                m_grant = -1;
                m_cool  = 0;
            end else if (m_grant >= 0) begin
                if (ack) begin
                    clr     = clr | (8'd1 << m_grant);
                    m_last  = m_grant;
                    m_grant = -1;
                    m_cool  = HOLDOFF;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if ((m_pending & m_mask) != 8'd0) begin
                m_grant = pick(m_pending & m_mask, m_cfg[2], m_last);
            end

            if (bus.wr) begin
                case (off)
                    1: m_cfg  = bus.wdata[2:0];
                    2: m_mask = bus.wdata[7:0];
                    3: clr    = clr | bus.wdata[7:0];
                    default: ;
                endcase
            end
            m_pending = (m_pending & ~clr) | rising;
        end
    end

    // Compare DUT outputs with the model on every falling edge
    always @(negedge clk) begin
        check_output("irq_cycle", {31'd0, irq}, {31'd0, m_irq});
        check_output("rvalid_cycle", {31'd0, bus.rvalid}, {31'd0, m_rvalid});
        if (m_rvalid) begin
            check_output("rdata_cycle", bus.rdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply_stimulus(input logic [7:0] v);
        @(negedge clk);
        src = v;
    endtask

    task automatic bus_write(input int off, input logic [31:0] data);
        @(negedge clk);
        bus.addr  = 32'(BASE + off);
        bus.wdata = data;
        bus.wr    = 1'b1;
        @(negedge clk);
        bus.wr    = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic bus_read(input int off, output logic [31:0] data);
        @(negedge clk);
        bus.addr = 32'(BASE + off);
        bus.rd   = 1'b1;
        @(negedge clk);
        bus.rd   = 1'b0;
        data     = bus.rdata;
    endtask

    task automatic wait_irq(input logic lvl, input string name);
        int n;
        n = 0;
        while (irq !== lvl && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_output(name, {31'd0, irq}, {31'd0, lvl});
    endtask

    // Directed sequence
    initial begin
        logic [31:0] rd;
        int          gap;
        int          fp_order [3];
        int          rr_order [4];

        fp_order = '{2, 5, 7};
        rr_order = '{1, 3, 1, 3};
        n_checks  = 0;
        n_errors  = 0;
        resetn    = 1'b0;
        src       = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // ID and reset values
        bus_read(0, rd);
        check_output("id", rd, 32'h0008_1A4B);
        bus_read(4, rd);
        check_output("cur_reset", rd, 32'h0);
        bus_read(3, rd);
        check_output("pending_reset", rd, 32'h0);
        check_output("irq_reset", {31'd0, irq}, 32'h0);

        // Single source timing
        bus_write(2, 32'h01);
        bus_write(1, 32'h1);
        apply_stimulus(8'h01);
        @(negedge clk);
        @(negedge clk);
        src = 8'h00;
        check_output("irq_edge_plus2", {31'd0, irq}, 32'h0);
        @(negedge clk);
        check_output("irq_edge_plus3", {31'd0, irq}, 32'h1);
        bus_read(4, rd);
        check_output("cur_single", rd, 32'h8000_0000);
        bus_write(5, 32'h0);
        check_output("irq_ack_plus1", {31'd0, irq}, 32'h1);
        @(negedge clk);
        check_output("irq_ack_plus2", {31'd0, irq}, 32'h0);
        bus_read(3, rd);
        check_output("pending_after_ack", rd, 32'h0);

        // Fixed priority with simultaneous edges on 5, 2, 7
        bus_write(2, 32'hFF);
        apply_stimulus(8'hA4);
        apply_stimulus(8'h00);
        for (int i = 0; i < 3; i++) begin
            wait_irq(1'b1, "fp_wait_grant");
            bus_read(4, rd);
            check_output("fp_cur", rd, 32'h8000_0000 | 32'(fp_order[i]));
            bus_write(5, 32'h0);
            if (i < 2) begin
                wait_irq(1'b0, "fp_wait_idle");
                gap = 0;
                while (irq !== 1'b1 && gap < 40) begin
                    gap++;
                    @(negedge clk);
                end
                check_output("fp_gap_min", {31'd0, gap >= HOLDOFF + 1}, 32'h1);
            end
        end
        bus_read(3, rd);
        check_output("fp_pending_empty", rd, 32'h0);

        // Round-robin with sources 1 and 3 re-pulsed after each acknowledge
        bus_write(1, 32'h5);
        apply_stimulus(8'h0A);
        apply_stimulus(8'h00);
        for (int i = 0; i < 4; i++) begin
            wait_irq(1'b1, "rr_wait_grant");
            bus_read(4, rd);
            check_output("rr_cur", rd, 32'h8000_0000 | 32'(rr_order[i]));
            bus_write(5, 32'h0);
            if (i < 3) begin
                apply_stimulus(8'(1 << rr_order[i]));
                apply_stimulus(8'h00);
            end
        end
        bus_write(1, 32'h0);
        bus_write(3, 32'hFF);
        bus_read(3, rd);
        check_output("rr_pending_cleared", rd, 32'h0);

        // Mask gating and disable mid-grant
        bus_write(2, 32'hEF);
        bus_write(1, 32'h1);
        apply_stimulus(8'h10);
        apply_stimulus(8'h00);
        repeat (6) @(negedge clk);
        check_output("masked_irq_idle", {31'd0, irq}, 32'h0);
        bus_read(3, rd);
        check_output("masked_pending", rd, 32'h10);
        bus_write(2, 32'hFF);
        wait_irq(1'b1, "unmask_grant");
        bus_read(4, rd);
        check_output("unmask_cur", rd, 32'h8000_0004);
        bus_write(1, 32'h0);
        @(negedge clk);
        check_output("disable_irq_drop", {31'd0, irq}, 32'h0);
        bus_read(3, rd);
        check_output("disable_pending_kept", rd, 32'h10);
        bus_write(3, 32'h10);

        // Polarity inversion
        bus_write(1, 32'h2);
        @(negedge clk);
        check_output("pol_idle_high", {31'd0, irq}, 32'h1);
        bus_write(2, 32'h40);
        bus_write(1, 32'h3);
        apply_stimulus(8'h40);
        apply_stimulus(8'h00);
        wait_irq(1'b0, "pol_active_low");
        bus_read(4, rd);
        check_output("pol_cur", rd, 32'h8000_0006);

        // W1C colliding with a new edge on the same source
        @(negedge clk);
        bus.addr  = 32'(BASE + 3);
        bus.wdata = 32'h40;
        bus.wr    = 1'b1;
        src       = 8'h40;
        @(negedge clk);
        bus.wr    = 1'b0;
        bus.wdata = '0;
        src       = 8'h00;
        bus_read(3, rd);
        check_output("collision_pending", rd, 32'h40);

        // Asynchronous reset during a grant
        bus_write(1, 32'h1);
        @(negedge clk);
        check_output("pre_reset_irq", {31'd0, irq}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check_output("async_reset_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        bus_read(1, rd);
        check_output("cfg_after_reset", rd, 32'h0);
        bus_read(4, rd);
        check_output("cur_after_reset", rd, 32'h0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got stalled run, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
